// File: rtl/sgpr_busy_table.sv
// Busy scoreboard for the scalar register file: dispatch marks SGPRs pending,
// writeback notifications clear them, and two lookup ports report hazards.
module sgpr_busy_table #(
    parameter int unsigned NUM_SGPR = 512,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_en,
    input  logic [ADDR_W-1:0] dispatch_addr,
    input  logic [3:0]        dispatch_mask,
    input  logic [ADDR_W-1:0] issue_alu_dest_reg_addr,
    input  logic [1:0]        issue_alu_dest_reg_valid,
    input  logic [ADDR_W-1:0] issue_lsu_dest_reg_addr,
    input  logic [3:0]        issue_lsu_dest_reg_valid,
    input  logic [ADDR_W-1:0] issue_valu_dest_addr,
    input  logic              issue_valu_dest_reg_valid,
    input  logic [ADDR_W-1:0] chk0_addr,
    input  logic [3:0]        chk0_mask,
    input  logic [ADDR_W-1:0] chk1_addr,
    input  logic [3:0]        chk1_mask,
    output logic              chk0_busy,
    output logic              chk1_busy,
    output logic [ADDR_W:0]   busy_count,
    output logic              table_empty,
    output logic              waw_err,
    output logic [ADDR_W-1:0] waw_err_addr,
    input  logic              err_clr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [NUM_SGPR-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic [NUM_SGPR-1:0] clr_vec, set_vec;
    logic [ADDR_W-1:0]   cpos [8];
    logic [7:0]          cval;
    logic [ADDR_W-1:0]   dpos [4];
    logic [3:0]          dval;
    logic [2:0]          rise;
    logic [3:0]          fall;
    logic                dup;
    logic                hit;
    logic [ADDR_W-1:0]   hit_addr;

    always_comb begin
        clr_vec  = '0;
        set_vec  = '0;
        cval     = '0;
        dval     = '0;
        rise     = '0;
        fall     = '0;
        dup      = 1'b0;
        hit      = 1'b0;
        hit_addr = '0;
        for (int unsigned i = 0; i < 8; i++) cpos[i] = '0;
        for (int unsigned i = 0; i < 4; i++) dpos[i] = '0;

        for (int unsigned i = 0; i < 2; i++) begin
            cpos[i] = issue_alu_dest_reg_addr + ADDR_W'(i);
            cval[i] = issue_alu_dest_reg_valid[i];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            cpos[2+i] = issue_lsu_dest_reg_addr + ADDR_W'(i);
            cval[2+i] = issue_lsu_dest_reg_valid[i];
        end
        cpos[6] = issue_valu_dest_addr;
        cpos[7] = issue_valu_dest_addr + ADDR_W'(1);
        cval[6] = issue_valu_dest_reg_valid;
        cval[7] = issue_valu_dest_reg_valid;

        for (int unsigned j = 0; j < 8; j++) begin
            if (cval[j]) clr_vec[cpos[j]] = 1'b1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            dpos[i] = dispatch_addr + ADDR_W'(i);
            dval[i] = dispatch_en & dispatch_mask[i];
            if (dval[i]) set_vec[dpos[i]] = 1'b1;
        end

        busy_d = (busy_q & ~clr_vec) | set_vec;

        // Count only real transitions; clear slots from different paths may
        // alias the same register, so later duplicates are skipped.
        for (int unsigned i = 0; i < 4; i++) begin
            if (dval[i] && !busy_q[dpos[i]]) rise = rise + 3'd1;
        end
        for (int unsigned j = 0; j < 8; j++) begin
            dup = 1'b0;
            for (int unsigned k = 0; k < j; k++) begin
                if (cval[k] && (cpos[k] == cpos[j])) dup = 1'b1;
            end
            if (cval[j] && !dup && busy_q[cpos[j]] && !set_vec[cpos[j]]) fall = fall + 4'd1;
        end
        count_d = count_q + CNT_W'(rise) - CNT_W'(fall);

        for (int unsigned i = 0; i < 4; i++) begin
            if (!hit && dval[i] && busy_q[dpos[i]] && !clr_vec[dpos[i]]) begin
                hit      = 1'b1;
                hit_addr = dpos[i];
            end
        end

        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (hit && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_addr_d = hit_addr;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        chk0_busy = 1'b0;
        chk1_busy = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            chk0_busy = chk0_busy | (chk0_mask[i] & busy_q[chk0_addr + ADDR_W'(i)]);
            chk1_busy = chk1_busy | (chk1_mask[i] & busy_q[chk1_addr + ADDR_W'(i)]);
        end
    end

    assign busy_count   = count_q;
    assign table_empty  = (count_q == '0);
    assign waw_err      = err_q;
    assign waw_err_addr = err_addr_q;

endmodule

// File: tb/tb_sgpr_busy_table.sv
// Scoreboard bench for sgpr_busy_table: directed stimulus pushes expected state,
// a negedge monitor pops and compares.
module tb_sgpr_busy_table;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dispatch_en = 1'b0;
    logic [8:0] dispatch_addr = '0;
    logic [3:0] dispatch_mask = '0;
    logic [8:0] alu_addr = '0;
    logic [1:0] alu_valid = '0;
    logic [8:0] lsu_addr = '0;
    logic [3:0] lsu_valid = '0;
    logic [8:0] valu_addr = '0;
    logic       valu_valid = 1'b0;
    logic [8:0] chk0_addr = '0;
    logic [3:0] chk0_mask = '0;
    logic [8:0] chk1_addr = '0;
    logic [3:0] chk1_mask = '0;
    logic       err_clr = 1'b0;
    logic       chk0_busy, chk1_busy, table_empty, waw_err;
    logic [9:0] busy_count;
    logic [8:0] waw_err_addr;

    sgpr_busy_table #(.NUM_SGPR(512), .ADDR_W(9)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .dispatch_en               (dispatch_en),
        .dispatch_addr             (dispatch_addr),
        .dispatch_mask             (dispatch_mask),
        .issue_alu_dest_reg_addr   (alu_addr),
        .issue_alu_dest_reg_valid  (alu_valid),
        .issue_lsu_dest_reg_addr   (lsu_addr),
        .issue_lsu_dest_reg_valid  (lsu_valid),
        .issue_valu_dest_addr      (valu_addr),
        .issue_valu_dest_reg_valid (valu_valid),
        .chk0_addr                 (chk0_addr),
        .chk0_mask                 (chk0_mask),
        .chk1_addr                 (chk1_addr),
        .chk1_mask                 (chk1_mask),
        .chk0_busy                 (chk0_busy),
        .chk1_busy                 (chk1_busy),
        .busy_count                (busy_count),
        .table_empty               (table_empty),
        .waw_err                   (waw_err),
        .waw_err_addr              (waw_err_addr),
        .err_clr                   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] cnt;
        logic       empty;
        logic       c0;
        logic       c1;
        logic       err;
        logic [8:0] eaddr;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (busy_count !== e.cnt || table_empty !== e.empty || chk0_busy !== e.c0 ||
                chk1_busy !== e.c1 || waw_err !== e.err || waw_err_addr !== e.eaddr) begin
                failed++;
                $display("FAIL %s: got cnt=%0d empty=%b c0=%b c1=%b err=%b eaddr=%0d, want cnt=%0d empty=%b c0=%b c1=%b err=%b eaddr=%0d",
                         e.name, busy_count, table_empty, chk0_busy, chk1_busy, waw_err, waw_err_addr,
                         e.cnt, e.empty, e.c0, e.c1, e.err, e.eaddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_en = 1'b0; dispatch_mask = '0;
        alu_valid = '0; lsu_valid = '0; valu_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic dispatch(input logic [8:0] a, input logic [3:0] m);
        dispatch_en = 1'b1; dispatch_addr = a; dispatch_mask = m;
    endtask

    // Sets lookup ports and queues the state expected at the coming negedge.
    task automatic chk(input string name, input logic [8:0] a0, input logic [3:0] m0,
                       input logic [8:0] a1, input logic [3:0] m1, input logic [9:0] cnt,
                       input logic c0, input logic c1, input logic err, input logic [8:0] eaddr);
        exp_t e;
        chk0_addr = a0; chk0_mask = m0; chk1_addr = a1; chk1_mask = m1;
        e.name = name; e.cnt = cnt; e.empty = (cnt == 10'd0);
        e.c0 = c0; e.c1 = c1; e.err = err; e.eaddr = eaddr;
        exp_q.push_back(e);
    endtask

    initial begin
        tick();
        chk("in_reset", 0, 4'hf, 300, 4'hf, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("after_reset", 511, 4'hf, 100, 4'hf, 0, 0, 0, 0, 0);
        tick();

        dispatch(10, 4'b1111);
        tick(); idle();
        chk("disp10", 12, 4'b0001, 14, 4'b0001, 4, 1, 0, 0, 0);
        tick();
        chk("mask0", 10, 4'b0000, 13, 4'b0001, 4, 0, 1, 0, 0);
        tick();

        lsu_addr = 10; lsu_valid = 4'b0011;
        alu_addr = 12; alu_valid = 2'b11;
        chk("clr_not_yet", 10, 4'b0001, 13, 4'b1000, 4, 1, 0, 0, 0);
        tick(); idle();
        chk("clr_all", 10, 4'hf, 12, 4'hf, 0, 0, 0, 0, 0);
        tick();

        dispatch(511, 4'b0011);
        tick(); idle();
        chk("wrap_set", 511, 4'b0001, 510, 4'b0100, 2, 1, 1, 0, 0);
        valu_addr = 511; valu_valid = 1'b1;
        tick(); idle();
        chk("wrap_clr", 511, 4'b0011, 510, 4'hf, 0, 0, 0, 0, 0);
        tick();

        dispatch(40, 4'b0001);
        tick(); idle();
        chk("r40_set", 40, 4'b0001, 41, 4'b0001, 1, 1, 0, 0, 0);
        dispatch(40, 4'b0001);
        alu_addr = 40; alu_valid = 2'b01;
        tick(); idle();
        chk("r40_setclr", 40, 4'b0001, 39, 4'b0001, 1, 1, 0, 0, 0);
        tick();

        dispatch(7, 4'b0001);
        tick(); idle();
        chk("r7_set", 7, 4'b0001, 8, 4'b0001, 2, 1, 0, 0, 0);
        dispatch(7, 4'b0001);
        tick(); idle();
        chk("waw7", 7, 4'b0001, 40, 4'b0001, 2, 1, 1, 1, 7);
        dispatch(9, 4'b0001);
        tick();
        tick(); idle();
        chk("waw9_hold", 9, 4'b0001, 8, 4'b0001, 3, 1, 0, 1, 7);
        err_clr = 1'b1;
        tick(); idle();
        chk("err_clr", 7, 4'b0101, 10, 4'hf, 3, 1, 0, 0, 0);
        dispatch(7, 4'b0101);
        alu_addr = 7; alu_valid = 2'b01;
        err_clr = 1'b1;
        tick(); idle();
        chk("waw_lowest", 7, 4'b0001, 9, 4'b0001, 3, 1, 1, 1, 9);
        tick();

        dispatch(100, 4'hf);
        rst = 1'b0;
        chk("rst_mid", 7, 4'b0001, 40, 4'b0001, 0, 0, 0, 0, 0);
        tick(); idle();
        rst = 1'b1;
        tick();
        chk("post_rst", 100, 4'hf, 9, 4'b0001, 0, 0, 0, 0, 0);
        tick();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
